ocm_stream_buffer: RTL and testbench

Parametrised on-chip sample memory for the SERDES noise/channel simulation path. An Avalon-MM slave port lets the host load and read back words with byte enables and a registered read. An independent streaming read port plays a programmable address window out continuously with valid/ready backpressure, wrapping at the window end. It replaces the fixed 1024×32 single-port on-chip memory wherever samples must be fed to the datapath at one word per clock.

---
 rtl/ocm_stream_pkg.sv | 18 +
 rtl/ocm_dp_ram.sv | 51 +++++
 rtl/ocm_stream_buffer.sv | 246 ++++++++++++++++++++++++
 tb/tb_ocm_stream_buffer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocm_stream_pkg.sv
// Shared types and helpers for the on-chip stream sample buffer.
// State encoding for the playback FSM and the per-byte parity function.
package ocm_stream_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Even parity bit for one byte lane.
   function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/ocm_dp_ram.sv
// Simple dual-port inferred RAM: port A read/write with lane enables,
// port B read only; both outputs registered, read-before-write.
module ocm_dp_ram #(
   parameter  int LANES  = 4,
   parameter  int LANE_W = 8,
   parameter  int DEPTH  = 1024,
   localparam int AW     = $clog2(DEPTH),
   localparam int W      = LANES * LANE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_a,
   input  logic [LANES-1:0] we_a,
   input  logic [AW-1:0]    addr_a,
   input  logic [W-1:0]     wdata_a,
   output logic [W-1:0]     rdata_a,
   input  logic             en_b,
   input  logic [AW-1:0]    addr_b,
   output logic [W-1:0]     rdata_b
);

   logic [W-1:0] mem [DEPTH];

   // Lane-masked writes through port A
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we_a[i]) begin
            mem[addr_a][i*LANE_W +: LANE_W] <= wdata_a[i*LANE_W +: LANE_W];
         end
      end
   end

   // Port A registered read; holds between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_a <= '0;
      end else if (en_a) begin
         rdata_a <= mem[addr_a];
      end
   end

   // Port B registered read; sees old data on same-cycle write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_b <= '0;
      end else if (en_b) begin
         rdata_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/ocm_stream_buffer.sv
// On-chip sample memory: Avalon-MM host port plus a windowed stream player.
// Optional byte parity storage/checking enabled by OCM_STREAM_PARITY_EN.
module ocm_stream_buffer
   import ocm_stream_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int NB     = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reset_req,
   input  logic              clken,
   input  logic [ADDR_W-1:0] address,
   input  logic [NB-1:0]     byteenable,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid,
   input  logic              play_en,
   input  logic [ADDR_W-1:0] play_base,
   input  logic [ADDR_W-1:0] play_len,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              wrap_pulse,
   output logic              busy,
   output logic              parity_err
);

`ifdef OCM_STREAM_PARITY_EN
   localparam int LANE_W = BYTE_W + 1;
`else
   localparam int LANE_W = BYTE_W;
`endif
   localparam int RAM_W = NB * LANE_W;
   localparam int FW    = DATA_W + 1;
   localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic              load, flush;
   logic [ADDR_W-1:0] base_q, end_q, ptr_q;
   logic              inflight_q, inflight_end_q;
   logic [1:0]        count_q;
   logic [FW-1:0]     slot0_q, slot1_q, din;
   logic              rdv_q;
   logic              wr_acc, rd_acc;
   logic              issue, push, pop, credit;
   logic [2:0]        occ;
   logic [NB-1:0]     we_a;
   logic [RAM_W-1:0]  wr_word, ram_a, ram_b;
   logic [DATA_W-1:0] data_a, data_b;

   assign wr_acc = chipselect & write & clken & ~reset_req;
   assign rd_acc = chipselect & read & ~write & clken & ~reset_req;
   assign we_a   = wr_acc ? byteenable : '0;

   // Pack host write data into RAM lanes
   always_comb begin
      wr_word = '0;
      for (int i = 0; i < NB; i++) begin
         wr_word[i*LANE_W +: BYTE_W] = writedata[i*BYTE_W +: BYTE_W];
`ifdef OCM_STREAM_PARITY_EN
         wr_word[i*LANE_W + BYTE_W] =
            byte_parity(writedata[i*BYTE_W +: BYTE_W]);
`endif
      end
   end

   // Strip lane padding from both read ports
   always_comb begin
      data_a = '0;
      data_b = '0;
      for (int i = 0; i < NB; i++) begin
         data_a[i*BYTE_W +: BYTE_W] = ram_a[i*LANE_W +: BYTE_W];
         data_b[i*BYTE_W +: BYTE_W] = ram_b[i*LANE_W +: BYTE_W];
      end
   end

   ocm_dp_ram #(
      .LANES  (NB),
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (reset),
      .en_a    (rd_acc),
      .we_a    (we_a),
      .addr_a  (address),
      .wdata_a (wr_word),
      .rdata_a (ram_a),
      .en_b    (issue),
      .addr_b  (ptr_q),
      .rdata_b (ram_b)
   );

   // Next-state logic; everything holds while reset_req is high
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      flush   = 1'b0;
      if (!reset_req) begin
         unique case (state_q)
            IDLE: begin
               if (play_en) begin
                  state_d = RUN;
                  load    = 1'b1;
               end
            end
            RUN: begin
               if (!play_en) begin
                  state_d = FLUSH;
                  flush   = 1'b1;
               end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Credit check keeps FIFO plus in-flight read within two words
   always_comb begin
      occ    = {1'b0, count_q} + {2'b00, inflight_q};
      pop    = (count_q != 2'd0) & sample_ready & ~reset_req;
      credit = pop ? (occ <= 3'd2) : (occ <= 3'd1);
      issue  = (state_q == RUN) & play_en & ~reset_req & credit;
      push   = inflight_q & (state_q == RUN) & play_en & ~reset_req;
      din    = {inflight_end_q, data_b};
   end

   // Window pointer and in-flight read tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q         <= '0;
         end_q          <= '0;
         ptr_q          <= '0;
         inflight_q     <= 1'b0;
         inflight_end_q <= 1'b0;
      end else if (!reset_req) begin
         if (load) begin
            base_q <= play_base;
            end_q  <= play_base + play_len - A_ONE;
            ptr_q  <= play_base;
         end else if (issue) begin
            ptr_q <= (ptr_q == end_q) ? base_q : ptr_q + A_ONE;
         end
         inflight_q <= issue;
         if (issue) begin
            inflight_end_q <= (ptr_q == end_q);
         end
      end
   end

   // Two-entry output skid FIFO; slot0 is the head
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= 2'd0;
         slot0_q <= '0;
         slot1_q <= '0;
      end else if (!reset_req) begin
         if (flush) begin
            count_q <= 2'd0;
         end else begin
            unique case ({push, pop})
               2'b10: begin
                  if (count_q == 2'd0) slot0_q <= din;
                  else                 slot1_q <= din;
                  count_q <= count_q + 2'd1;
               end
               2'b01: begin
                  slot0_q <= slot1_q;
                  count_q <= count_q - 2'd1;
               end
               2'b11: begin
                  if (count_q == 2'd1) begin
                     slot0_q <= din;
                  end else begin
                     slot0_q <= slot1_q;
                     slot1_q <= din;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Host read valid pulse, one cycle after acceptance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdv_q <= 1'b0;
      end else begin
         rdv_q <= rd_acc;
      end
   end

`ifdef OCM_STREAM_PARITY_EN
   logic bad_a, bad_b, perr_q;

   // Per-lane parity recheck on both read paths
   always_comb begin
      bad_a = 1'b0;
      bad_b = 1'b0;
      for (int i = 0; i < NB; i++) begin
         bad_a = bad_a | (byte_parity(ram_a[i*LANE_W +: BYTE_W])
                          != ram_a[i*LANE_W + BYTE_W]);
         bad_b = bad_b | (byte_parity(ram_b[i*LANE_W +: BYTE_W])
                          != ram_b[i*LANE_W + BYTE_W]);
      end
   end

   // Sticky parity error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perr_q <= 1'b0;
      end else if ((rdv_q & bad_a) | (push & bad_b)) begin
         perr_q <= 1'b1;
      end
   end

   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   assign readdata      = data_a;
   assign readdatavalid = rdv_q;
   assign sample_data   = slot0_q[DATA_W-1:0];
   assign sample_valid  = (count_q != 2'd0);
   assign wrap_pulse    = pop & slot0_q[DATA_W];
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ocm_stream_buffer.sv
// Scoreboard bench for ocm_stream_buffer: host port and windowed stream.
// Expected words come from a memory model and window arithmetic.
module tb_ocm_stream_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          reset_req = 1'b0;
   logic          clken = 1'b1;
   logic [AW-1:0] address = '0;
   logic [3:0]    byteenable = '0;
   logic          chipselect = 1'b0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [DW-1:0] writedata = '0;
   logic [DW-1:0] readdata;
   logic          readdatavalid;
   logic          play_en = 1'b0;
   logic [AW-1:0] play_base = '0;
   logic [AW-1:0] play_len = '0;
   logic [DW-1:0] sample_data;
   logic          sample_valid;
   logic          sample_ready = 1'b0;
   logic          wrap_pulse;
   logic          busy;
   logic          parity_err;

   ocm_stream_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
      .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata),
      .readdatavalid(readdatavalid), .play_en(play_en),
      .play_base(play_base), .play_len(play_len),
      .sample_data(sample_data), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .wrap_pulse(wrap_pulse),
      .busy(busy), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] tb_mem [DEPTH];
   logic [DW-1:0] av_q [$];
   logic [DW:0]   st_q [$];
   int n_cmp = 0;
   int n_bad = 0;
   int n_acc = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expected responses whenever the DUT presents one
   initial begin : mon
      logic          hold;
      logic [DW-1:0] hold_d;
      hold = 1'b0;
      hold_d = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold = 1'b0;
            continue;
         end
         if (hold) begin
            chk("stable_valid", sample_valid, 1);
            chk("stable_data", sample_data, hold_d);
         end
         if (readdatavalid) begin
            chk("av_expected", av_q.size() != 0, 1);
            if (av_q.size() != 0) chk("readdata", readdata, av_q.pop_front());
         end
         if (sample_valid && sample_ready && !reset_req) begin
            n_acc++;
            chk("st_expected", st_q.size() != 0, 1);
            if (st_q.size() != 0)
               chk("stream", {wrap_pulse, sample_data}, st_q.pop_front());
         end else if (wrap_pulse) begin
            chk("wrap_no_accept", wrap_pulse, 0);
         end
         hold = sample_valid & ~sample_ready & play_en & ~reset_req;
         hold_d = sample_data;
      end
   end

   task automatic av_write(input int a, input logic [31:0] d,
                           input logic [3:0] be);
      chipselect = 1'b1; write = 1'b1;
      address = a[AW-1:0]; writedata = d; byteenable = be;
      tick();
      chipselect = 1'b0; write = 1'b0;
      for (int i = 0; i < 4; i++)
         if (be[i]) tb_mem[a][i*8 +: 8] = d[i*8 +: 8];
   endtask

   task automatic av_read(input int a, input logic [31:0] exp);
      chipselect = 1'b1; read = 1'b1; address = a[AW-1:0];
      @(posedge clk);
      av_q.push_back(exp);
      #1;
      chipselect = 1'b0; read = 1'b0;
      @(negedge clk);
      chk("rdv_pulse", readdatavalid, 1);
      @(negedge clk);
      chk("rdv_single", readdatavalid, 0);
   endtask

   task automatic start(input int b, input int l, input int nexp);
      int len;
      len = (l == 0) ? DEPTH : l;
      st_q.delete();
      for (int k = 0; k < nexp; k++) begin
         int a;
         a = (b + (k % len)) % DEPTH;
         st_q.push_back({((k % len) == len - 1), tb_mem[a]});
      end
      play_base = b[AW-1:0];
      play_len = l[AW-1:0];
      play_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("start_busy", busy, 1);
      chk("start_v_n", sample_valid, 0);
      @(negedge clk);
      chk("start_v_n1", sample_valid, 0);
      @(negedge clk);
      chk("start_v_n2", sample_valid, 1);
      play_base = AW'($urandom);
      play_len = AW'($urandom);
   endtask

   task automatic stop();
      play_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("stop_valid", sample_valid, 0);
      chk("stop_busy_flush", busy, 1);
      @(negedge clk);
      chk("stop_busy_idle", busy, 0);
      st_q.delete();
   endtask

   initial begin : stim
      int acc0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_readdata", readdata, 0);
      chk("rst_rdv", readdatavalid, 0);
      chk("rst_sdata", sample_data, 0);
      chk("rst_svalid", sample_valid, 0);
      chk("rst_wrap", wrap_pulse, 0);
      chk("rst_busy", busy, 0);
      chk("rst_perr", parity_err, 0);
      reset = 1'b0;
      tick();

      // Byte-enable merge
      av_write(5, 32'h0, 4'hf);
      av_write(5, 32'hDEADBEEF, 4'b0101);
      av_read(5, 32'h00AD00EF);

      // clken low: neither write nor read accepted
      clken = 1'b0; chipselect = 1'b1; write = 1'b1;
      address = 5; writedata = 32'hFFFFFFFF; byteenable = 4'hf;
      tick();
      write = 1'b0; read = 1'b1;
      tick();
      chipselect = 1'b0; read = 1'b0; clken = 1'b1;
      @(negedge clk);
      chk("clken_rdv", readdatavalid, 0);
      av_read(5, tb_mem[5]);

      // Load ramp
      for (int i = 0; i < DEPTH; i++) av_write(i, i, 4'hf);

      // Random partial writes with readback, away from the stream windows
      for (int n = 0; n < 30; n++) begin
         int a;
         a = $urandom_range(100, 900);
         av_write(a, $urandom, 4'($urandom_range(0, 15)));
         av_read(a, tb_mem[a]);
      end

      // reset_req suppresses both strobes
      reset_req = 1'b1; chipselect = 1'b1; write = 1'b1;
      address = 9; writedata = 32'hA5A5A5A5; byteenable = 4'hf;
      tick();
      write = 1'b0; read = 1'b1;
      tick();
      chipselect = 1'b0; read = 1'b0;
      @(negedge clk);
      chk("rreq_rdv", readdatavalid, 0);
      reset_req = 1'b0;
      av_read(9, tb_mem[9]);

      // Window 1020..3 at full rate
      sample_ready = 1'b1;
      start(1020, 8, 80);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         chk("thruput", sample_valid, 1);
      end
      tick();
      sample_ready = 1'b0;
      repeat (4) tick();
      chk("bp_hold", sample_valid, 1);
      stop();

      // Restart at base, random backpressure
      tick();
      start(1020, 8, 600);
      acc0 = n_acc;
      for (int c = 0; c < 500; c++) begin
         tick();
         sample_ready = 1'($urandom_range(0, 1));
      end
      chk("bp_progress", n_acc - acc0 > 150, 1);
      stop();

      // Full-depth window
      tick();
      sample_ready = 1'b1;
      start(0, 0, 1100);
      repeat (1040) tick();
      stop();

      // Random windows with a reset_req stall mid-run
      for (int r = 0; r < 3; r++) begin
         tick();
         start($urandom_range(0, DEPTH - 1), $urandom_range(1, 16), 200);
         for (int c = 0; c < 150; c++) begin
            tick();
            sample_ready = 1'($urandom_range(0, 1));
            reset_req = (c >= 70 && c < 73);
         end
         reset_req = 1'b0;
         stop();
      end

      // Asynchronous reset mid-run
      tick();
      sample_ready = 1'b1;
      start(5, 10, 100);
      repeat (10) tick();
      #2;
      reset = 1'b1;
      play_en = 1'b0;
      #1;
      chk("arst_valid", sample_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_wrap", wrap_pulse, 0);
      chk("arst_sdata", sample_data, 0);
      st_q.delete();
      tick();
      reset = 1'b0;
      tick();

`ifdef OCM_STREAM_PARITY_EN
      av_write(7, 32'h12345678, 4'hf);
      dut.u_ram.mem[7][0] = ~dut.u_ram.mem[7][0];
      tb_mem[7][0] = ~tb_mem[7][0];
      av_read(7, tb_mem[7]);
      tick();
      chk("perr_set", parity_err, 1);
      repeat (5) tick();
      chk("perr_sticky", parity_err, 1);
      reset = 1'b1;
      #1;
      chk("perr_clear", parity_err, 0);
      tick();
      reset = 1'b0;
      tick();
`else
      av_write(7, 32'h12345678, 4'hf);
      av_read(7, tb_mem[7]);
      tick();
      chk("perr_off", parity_err, 0);
`endif

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
